wb_mixer_rr: RTL and testbench

WB_MIXER_RR -- requirements
Module: wb_mixer_rr

---
 rtl/wb_mixer_pkg.sv | 22 ++
 rtl/wb_rr_arb.sv | 34 +++
 rtl/wb_mixer_rr.sv | 159 +++++++++++++++
 tb/tb_wb_mixer_rr.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mixer_pkg.sv
// Shared types for the round-robin Wishbone mixer: FSM states, channel-count limits, grant decode.
package wb_mixer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int NCH_MIN = 2;
  localparam int NCH_MAX = 16;

  // Index of a one-hot grant; OR-reduction keeps it a flat encoder.
  function automatic logic [3:0] gnt_idx(input logic [NCH_MAX-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < NCH_MAX; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Zero latency; no state, no backpressure of its own.
module wb_rr_arb
  import wb_mixer_pkg::*;
#(
  parameter int NCH = 5,
  parameter int PW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] gnt
);

  logic [PW:0]   sum;
  logic [PW-1:0] sel;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    sel   = '0;
    for (int i = 0; i < NCH; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NCH)) sum = sum - (PW+1)'(NCH);
      sel = sum[PW-1:0];
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_mixer_rr.sv
// N-to-1 Wishbone mixer with registered round-robin grant; optional watchdog under WB_MIXER_WDT_EN.
// Grant 1 cycle after cyc rises in IDLE, one IDLE cycle between owners; data path is combinational.
// No preemption: the owner holds the master until it drops cyc; others wait with cyc asserted.
module wb_mixer_rr
  import wb_mixer_pkg::*;
#(
  parameter int NCH = 5,
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int TMO = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [NCH-1:0]  wbs_cyc,
  input  logic [NCH-1:0]  wbs_stb,
  input  logic [NCH-1:0]  wbs_we,
  input  logic [NCH-1:0]  wbs_cab,
  input  logic [NCH-1:0]  wbs_pref,
  input  logic [4*NCH-1:0]  wbs_sel,
  input  logic [AW*NCH-1:0] wbs_adr,
  input  logic [DW*NCH-1:0] wbs_dat_i,
  input  logic [DW*NCH-1:0] wbs_dat64_i,
  output logic [DW*NCH-1:0] wbs_dat_o,
  output logic [DW*NCH-1:0] wbs_dat64_o,
  output logic [NCH-1:0]  wbs_ack,
  output logic [NCH-1:0]  wbs_err,
  output logic [NCH-1:0]  wbs_rty,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic            wbm_cab_o,
  output logic            wbm_pref_o,
  output logic [3:0]      wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW-1:0]   wbm_dat64_o,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  input  logic            wbm_rty_i,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic [DW-1:0]   wbm_dat64_i,
  output logic [NCH-1:0]  gnt_o
);

  localparam int PW = $clog2(NCH);

  if (NCH < NCH_MIN || NCH > NCH_MAX || TMO < 1) begin : g_bad_cfg
    $error("wb_mixer_rr: NCH or TMO out of range");
  end

  state_t         state, state_nxt;
  logic [NCH-1:0] gnt, gnt_nxt, pick;
  logic [PW-1:0]  rr_ptr, rr_ptr_nxt, cur_idx;
  logic           own_cyc;

  wb_rr_arb #(.NCH(NCH), .PW(PW)) u_arb (
    .req (wbs_cyc),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  assign own_cyc = |(wbs_cyc & gnt);
  assign cur_idx = PW'(gnt_idx(NCH_MAX'(gnt)));

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (|wbs_cyc) begin
          gnt_nxt   = pick;
          state_nxt = BUSY;
        end else begin
          gnt_nxt = '0;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_nxt  = IDLE;
          gnt_nxt    = '0;
          rr_ptr_nxt = (cur_idx == PW'(NCH-1)) ? '0 : cur_idx + PW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // AND-OR mux on the registered grant: an empty grant yields all-zero outputs.
  always_comb begin
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    wbm_we_o    = 1'b0;
    wbm_cab_o   = 1'b0;
    wbm_pref_o  = 1'b0;
    wbm_sel_o   = '0;
    wbm_adr_o   = '0;
    wbm_dat_o   = '0;
    wbm_dat64_o = '0;
    for (int k = 0; k < NCH; k++) begin
      wbm_cyc_o   = wbm_cyc_o   | (gnt[k] & wbs_cyc[k]);
      wbm_stb_o   = wbm_stb_o   | (gnt[k] & wbs_stb[k]);
      wbm_we_o    = wbm_we_o    | (gnt[k] & wbs_we[k]);
      wbm_cab_o   = wbm_cab_o   | (gnt[k] & wbs_cab[k]);
      wbm_pref_o  = wbm_pref_o  | (gnt[k] & wbs_pref[k]);
      wbm_sel_o   = wbm_sel_o   | ({4{gnt[k]}}  & wbs_sel[k*4 +: 4]);
      wbm_adr_o   = wbm_adr_o   | ({AW{gnt[k]}} & wbs_adr[k*AW +: AW]);
      wbm_dat_o   = wbm_dat_o   | ({DW{gnt[k]}} & wbs_dat_i[k*DW +: DW]);
      wbm_dat64_o = wbm_dat64_o | ({DW{gnt[k]}} & wbs_dat64_i[k*DW +: DW]);
    end
  end

  assign wbs_dat_o   = {NCH{wbm_dat_i}};
  assign wbs_dat64_o = {NCH{wbm_dat64_i}};
  assign wbs_ack     = {NCH{wbm_ack_i}} & gnt;
  assign wbs_rty     = {NCH{wbm_rty_i}} & gnt;
  assign gnt_o       = gnt;

`ifdef WB_MIXER_WDT_EN
  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] wdt_cnt;
  logic          wdt_hit, term;

  assign term    = wbm_ack_i | wbm_err_i | wbm_rty_i;
  assign wdt_hit = (wdt_cnt == CW'(TMO));

  // Counts stalled strobe cycles; the timeout errors the owner but keeps its grant.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wdt_cnt <= '0;
    end else if (state != BUSY || state_nxt != BUSY || term || wdt_hit) begin
      wdt_cnt <= '0;
    end else if (wbm_stb_o) begin
      wdt_cnt <= wdt_cnt + CW'(1);
    end
  end

  assign wbs_err = {NCH{wbm_err_i | wdt_hit}} & gnt;
`else
  assign wbs_err = {NCH{wbm_err_i}} & gnt;
`endif

endmodule

// File: tb/tb_wb_mixer_rr.sv
// Directed bench for wb_mixer_rr: vector table for mux/termination paths plus arbitration sequences.
module tb_wb_mixer_rr;

  localparam int NCH = 5;
  localparam int DW  = 32;
  localparam int AW  = 32;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    wbs_cyc, wbs_stb, wbs_we, wbs_cab, wbs_pref;
  logic [4*NCH-1:0]  wbs_sel;
  logic [AW*NCH-1:0] wbs_adr;
  logic [DW*NCH-1:0] wbs_dat_i, wbs_dat64_i, wbs_dat_o, wbs_dat64_o;
  logic [NCH-1:0]    wbs_ack, wbs_err, wbs_rty;
  logic              wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, wbm_pref_o;
  logic [3:0]        wbm_sel_o;
  logic [AW-1:0]     wbm_adr_o;
  logic [DW-1:0]     wbm_dat_o, wbm_dat64_o;
  logic              wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [DW-1:0]     wbm_dat_i, wbm_dat64_i;
  logic [NCH-1:0]    gnt_o;

  wb_mixer_rr #(.NCH(NCH), .DW(DW), .AW(AW), .TMO(16)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc     (wbs_cyc),
    .wbs_stb     (wbs_stb),
    .wbs_we      (wbs_we),
    .wbs_cab     (wbs_cab),
    .wbs_pref    (wbs_pref),
    .wbs_sel     (wbs_sel),
    .wbs_adr     (wbs_adr),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_dat64_i (wbs_dat64_i),
    .wbs_dat_o   (wbs_dat_o),
    .wbs_dat64_o (wbs_dat64_o),
    .wbs_ack     (wbs_ack),
    .wbs_err     (wbs_err),
    .wbs_rty     (wbs_rty),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_cab_o   (wbm_cab_o),
    .wbm_pref_o  (wbm_pref_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat64_o (wbm_dat64_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_err_i   (wbm_err_i),
    .wbm_rty_i   (wbm_rty_i),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_dat64_i (wbm_dat64_i),
    .gnt_o       (gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic        ack, err, rty;
    logic [31:0] mdat;
    logic [4:0]  exp_gnt;
    logic [31:0] exp_adr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdat;
    logic [31:0] exp_wdat64;
    logic        exp_we;
    logic [4:0]  exp_ack, exp_err, exp_rty;
  } vec_t;

  vec_t        tbl[5];
  logic [31:0] adr_tab[5];
  logic [3:0]  sel_tab[5];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic cyc, input logic cab);
    wbs_cyc[k] = cyc;
    wbs_stb[k] = cyc;
    wbs_cab[k] = cab;
  endtask

  initial begin
    logic [4:0] exp_err;

    adr_tab = '{32'h0000_0100, 32'h0000_0200, 32'h0000_1000, 32'h0000_3000, 32'h0000_4000};
    sel_tab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF};
    //            ch ack   err   rty   mdat          gnt       adr           sel   wdat          wdat64        we    ack       err       rty
    tbl[0] = '{2, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 5'b00100, 32'h0000_1000, 4'h4, 32'hD000_0002, 32'hE000_0002, 1'b0, 5'b00100, 5'b00000, 5'b00000};
    tbl[1] = '{3, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 5'b01000, 32'h0000_3000, 4'h8, 32'hD000_0003, 32'hE000_0003, 1'b1, 5'b00000, 5'b01000, 5'b01000};
    tbl[2] = '{0, 1'b1, 1'b1, 1'b0, 32'hA5A5_0001, 5'b00001, 32'h0000_0100, 4'h1, 32'hD000_0000, 32'hE000_0000, 1'b0, 5'b00001, 5'b00001, 5'b00000};
    tbl[3] = '{4, 1'b0, 1'b0, 1'b1, 32'h0F0F_1234, 5'b10000, 32'h0000_4000, 4'hF, 32'hD000_0004, 32'hE000_0004, 1'b0, 5'b00000, 5'b00000, 5'b10000};
    tbl[4] = '{1, 1'b1, 1'b0, 1'b1, 32'h8765_4321, 5'b00010, 32'h0000_0200, 4'h2, 32'hD000_0001, 32'hE000_0001, 1'b1, 5'b00010, 5'b00000, 5'b00010};

    rst = 1'b1;
    wbs_cyc = '0; wbs_stb = '0; wbs_cab = '0; wbs_pref = '0;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
    wbm_dat_i = '0; wbm_dat64_i = '0;
    for (int k = 0; k < NCH; k++) begin
      wbs_we[k]                  = k[0];
      wbs_sel[k*4 +: 4]          = sel_tab[k];
      wbs_adr[k*AW +: AW]        = adr_tab[k];
      wbs_dat_i[k*DW +: DW]      = 32'hD000_0000 | k;
      wbs_dat64_i[k*DW +: DW]    = 32'hE000_0000 | k;
    end

    // Reset state, with master terminations forced high to prove they are gated.
    repeat (3) tick;
    rst = 1'b0;
    wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_rty_i = 1'b1;
    #1;
    chk("rst_gnt", gnt_o, 5'b0);
    chk("rst_wbm_cyc", wbm_cyc_o, 1'b0);
    chk("rst_wbm_stb", wbm_stb_o, 1'b0);
    chk("rst_wbm_adr", wbm_adr_o, 32'h0);
    chk("rst_wbm_sel", wbm_sel_o, 4'h0);
    chk("rst_ack", wbs_ack, 5'b0);
    chk("rst_err", wbs_err, 5'b0);
    chk("rst_rty", wbs_rty, 5'b0);
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
    tick;
    chk("idle_gnt", gnt_o, 5'b0);

    // Single-owner vectors: master mux, termination steering, read-data broadcast.
    foreach (tbl[i]) begin
      set_ch(tbl[i].ch, 1'b1, 1'b0);
      tick;
      chk($sformatf("v%0d_gnt", i), gnt_o, tbl[i].exp_gnt);
      chk($sformatf("v%0d_cyc", i), {wbm_cyc_o, wbm_stb_o}, 2'b11);
      chk($sformatf("v%0d_adr", i), wbm_adr_o, tbl[i].exp_adr);
      chk($sformatf("v%0d_sel", i), wbm_sel_o, tbl[i].exp_sel);
      chk($sformatf("v%0d_wdat", i), wbm_dat_o, tbl[i].exp_wdat);
      chk($sformatf("v%0d_wdat64", i), wbm_dat64_o, tbl[i].exp_wdat64);
      chk($sformatf("v%0d_we", i), wbm_we_o, tbl[i].exp_we);
      wbm_ack_i = tbl[i].ack; wbm_err_i = tbl[i].err; wbm_rty_i = tbl[i].rty;
      wbm_dat_i = tbl[i].mdat; wbm_dat64_i = ~tbl[i].mdat;
      #1;
      chk($sformatf("v%0d_ack", i), wbs_ack, tbl[i].exp_ack);
      chk($sformatf("v%0d_err", i), wbs_err, tbl[i].exp_err);
      chk($sformatf("v%0d_rty", i), wbs_rty, tbl[i].exp_rty);
      chk($sformatf("v%0d_rdat", i), wbs_dat_o, {5{tbl[i].mdat}});
      chk($sformatf("v%0d_rdat64", i), wbs_dat64_o, {5{~tbl[i].mdat}});
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
      set_ch(tbl[i].ch, 1'b0, 1'b0);
      tick;
      chk($sformatf("v%0d_release", i), gnt_o, 5'b0);
    end

    // Three simultaneous requesters after reset: 0, then 1, then 3, one IDLE cycle apart.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    set_ch(0, 1'b1, 1'b0); set_ch(1, 1'b1, 1'b0); set_ch(3, 1'b1, 1'b0);
    tick;
    chk("rr_first", gnt_o, 5'b00001);
    set_ch(0, 1'b0, 1'b0);
    tick;
    chk("rr_gap1", gnt_o, 5'b00000);
    tick;
    chk("rr_second", gnt_o, 5'b00010);
    set_ch(1, 1'b0, 1'b0);
    tick;
    chk("rr_gap2", gnt_o, 5'b00000);
    tick;
    chk("rr_third", gnt_o, 5'b01000);
    set_ch(3, 1'b0, 1'b0);
    tick;

    // Burst on ch4 (pointer now 4) with ch0 waiting: no re-arbitration across 8 beats.
    set_ch(4, 1'b1, 1'b1); set_ch(0, 1'b1, 1'b0);
    tick;
    wbm_ack_i = 1'b1;
    for (int b = 0; b < 8; b++) begin
      #1;
      chk($sformatf("burst_gnt_b%0d", b), gnt_o, 5'b10000);
      chk($sformatf("burst_ack_b%0d", b), wbs_ack, 5'b10000);
      chk($sformatf("burst_cab_b%0d", b), wbm_cab_o, 1'b1);
      if (b < 7) tick;
    end
    wbm_ack_i = 1'b0;
    set_ch(4, 1'b0, 1'b0);
    tick;
    chk("burst_gap", gnt_o, 5'b00000);
    tick;
    chk("burst_next", gnt_o, 5'b00001);
    set_ch(0, 1'b0, 1'b0);
    tick;

    // Reset in the middle of a ch1 transfer.
    set_ch(1, 1'b1, 1'b0);
    tick;
    chk("midrst_gnt_before", gnt_o, 5'b00010);
    rst = 1'b1;
    set_ch(1, 1'b0, 1'b0);
    tick;
    rst = 1'b0;
    wbm_ack_i = 1'b1;
    #1;
    chk("midrst_gnt", gnt_o, 5'b0);
    chk("midrst_wbm_cyc", wbm_cyc_o, 1'b0);
    chk("midrst_ack", wbs_ack, 5'b0);
    wbm_ack_i = 1'b0;
    set_ch(3, 1'b1, 1'b0);
    tick;
    chk("midrst_ch3", gnt_o, 5'b01000);
    set_ch(3, 1'b0, 1'b0);
    tick;

    // Stalled strobe on ch2: timeout error only when the watchdog is built in.
    set_ch(2, 1'b1, 1'b0);
    tick;
    chk("wdt_gnt", gnt_o, 5'b00100);
    for (int n = 0; n <= 20; n++) begin
`ifdef WB_MIXER_WDT_EN
      exp_err = (n == 16) ? 5'b00100 : 5'b00000;
`else
      exp_err = 5'b00000;
`endif
      #1;
      chk($sformatf("wdt_err_n%0d", n), wbs_err, exp_err);
      chk($sformatf("wdt_hold_n%0d", n), gnt_o, 5'b00100);
      tick;
    end
    set_ch(2, 1'b0, 1'b0);
    tick;
    chk("wdt_release", gnt_o, 5'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
